ifetch32: RTL

Instruction fetch stage sitting directly upstream of the 32-bit instruction BRAM (1-cycle registered read, byte address, word-indexed) and feeding the decode stage. It owns the fetch PC, drives the BRAM address, and tracks the one in-flight read. It captures returning words into a 2-entry buffer and presents them to decode over a valid/ready handshake. It also handles branch redirects (flush) and a halt request without losing or duplicating instructions.

---
 rtl/ifetch32.sv | 101 ++++++++++
 1 files changed

// File: rtl/ifetch32.sv
// Instruction fetch stage: owns the fetch PC, drives the 1-cycle BRAM, and buffers
// returned words in a 2-entry FIFO toward decode with redirect and halt handling.
module ifetch32 #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  output logic [15:0] mem_a,
  input  logic [31:0] mem_di,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [15:0] instr_pc
);

  logic [15:0] fetch_pc;
  logic [15:0] inflight_pc;
  logic        inflight;
  logic [1:0]  count;
  logic [15:0] head_pc, tail_pc;
  logic [31:0] head_w, tail_w;

  logic        pop, push, issue;
  logic [2:0]  occ;

  always_comb begin
    pop   = instr_valid & instr_ready;
    push  = inflight & ~redirect;
    // Occupancy after this cycle's pop, counting the read already in flight.
    occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    issue = ~redirect & ~halt & (occ < 3'd2);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fetch_pc    <= RESET_PC & 16'hFFFC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & 16'hFFFC;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 16'd4;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count   <= '0;
      head_pc <= '0;
      head_w  <= '0;
      tail_pc <= '0;
      tail_w  <= '0;
    end else if (redirect) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (count == 2'd1) begin
            head_pc <= inflight_pc;
            head_w  <= mem_di;
          end else begin
            head_pc <= tail_pc;
            head_w  <= tail_w;
            tail_pc <= inflight_pc;
            tail_w  <= mem_di;
          end
        end
        2'b01: begin
          head_pc <= tail_pc;
          head_w  <= tail_w;
          count   <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) begin
            head_pc <= inflight_pc;
            head_w  <= mem_di;
          end else begin
            tail_pc <= inflight_pc;
            tail_w  <= mem_di;
          end
          count <= count + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem_a       = fetch_pc;
  assign instr_valid = (count != 2'd0);
  assign instr       = head_w;
  assign instr_pc    = head_pc;

endmodule
